// File: rtl/xs3_pkg.sv
// Shared definitions for the excess-3 serial decoder (and the future serial encoder).
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'd3;
  localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/xs3_digit_dec.sv
// Single-digit excess-3 to BCD decode; illegal codes give 0 and raise err.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       err
);

  // Legal range is 0x3..0xC; anything outside is flagged and zeroed.
  always_comb begin
    err = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
    bcd = err ? 4'd0 : (xs3 - XS3_OFFSET);
  end

endmodule

// File: rtl/xs3_to_bcd_serial.sv
// Serial excess-3 to BCD decoder: one digit per clock, LSD first,
// valid/ready on both sides, per-digit illegal-code mask.
//
// state | meaning
// IDLE  | waiting for a word, in_ready high
// CONV  | decoding digit cnt from the shift register low nibble
// DONE  | result presented, waiting for out_ready
module xs3_to_bcd_serial
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_xs3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_err,
  output logic [DIGITS-1:0]   out_err_mask
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state;
  state_t            state_next;
  logic [W-1:0]      shift_reg;
  logic [CW-1:0]     cnt;
  logic [W-1:0]      bcd_acc;
  logic [DIGITS-1:0] mask_acc;
  logic [W-1:0]      bcd_out;
  logic [DIGITS-1:0] mask_out;
  logic [W-1:0]      bcd_upd;
  logic [DIGITS-1:0] mask_upd;
  logic [3:0]        dig_bcd;
  logic              dig_err;
  logic              last_digit;

  xs3_digit_dec u_dec (
    .xs3 (shift_reg[3:0]),
    .bcd (dig_bcd),
    .err (dig_err)
  );

  assign last_digit = (cnt == CW'(DIGITS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CONV;
      end
      CONV: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulators with the current digit dropped into slot cnt.
  always_comb begin
    bcd_upd                   = bcd_acc;
    mask_upd                  = mask_acc;
    bcd_upd[{cnt, 2'b00} +: 4] = dig_bcd;
    mask_upd[cnt]             = dig_err;
  end

  // Datapath: capture, shift/accumulate, and publish the full result on the last digit
  // so the outputs keep the previous word until the new one is complete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt       <= '0;
      bcd_acc   <= '0;
      mask_acc  <= '0;
      bcd_out   <= '0;
      mask_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_xs3;
            cnt       <= '0;
            bcd_acc   <= '0;
            mask_acc  <= '0;
          end
        end
        CONV: begin
          shift_reg <= shift_reg >> 4;
          bcd_acc   <= bcd_upd;
          mask_acc  <= mask_upd;
          if (last_digit) begin
            bcd_out  <= bcd_upd;
            mask_out <= mask_upd;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_bcd      = bcd_out;
  assign out_err_mask = mask_out;
  assign out_err      = |mask_out;

endmodule
